// File: rtl/skid_rx_buffer_pkg.sv
// Shared state encoding for the skid_rx_buffer receive skid buffer.
// Occupancy is EMPTY, ONE or FULL. Main holds the head word and Skid holds the second word.
package skid_rx_pkg;
    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        ONE   = 2'd1,
        FULL  = 2'd2
    } skidstate_t;
endpackage

// File: rtl/skid_rx_buffer_dff_en.sv
// Purpose: WIDTH-bit enable flop with synchronous active-high reset, used for the Main and Skid entries.
// Latency: d appears on q one clock after an edge where en=1.
// Backpressure: none; en=0 holds the current value.
module skid_rx_buffer_dff_en #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             en,
    input  logic [WIDTH-1:0] d,
    output logic [WIDTH-1:0] q
);
    logic [WIDTH-1:0] data_d;
    logic [WIDTH-1:0] data_q;

    always_comb begin
        data_d = data_q;
        if (en) data_d = d;
    end

    always_ff @(posedge clk) begin
        if (reset) data_q <= '0;
        else       data_q <= data_d;
    end

    assign q = data_q;
endmodule

// File: rtl/skid_rx_buffer.sv
// Purpose: two-entry receive skid buffer. Defining SKID_RX_BUFFER_FLUSH_EN adds a Flush input.
// Latency: 1 cycle from acceptance to OutData when the buffer is empty or streaming.
// Backpressure: InReady comes from state flops only and drops when both entries are occupied.
module skid_rx_buffer
    import skid_rx_pkg::*;
#(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
`ifdef SKID_RX_BUFFER_FLUSH_EN
    input  logic             Flush,
`endif
    input  logic             InValid,
    output logic             InReady,
    input  logic [WIDTH-1:0] InData,
    output logic             OutValid,
    input  logic             OutReady,
    output logic [WIDTH-1:0] OutData
);
    skidstate_t       state_d, state_q;
    logic             in_fire, out_fire;
    logic             main_en, skid_en, main_from_skid;
    logic [WIDTH-1:0] main_in, skid_q;

    assign OutValid = (state_q != EMPTY);
    assign InReady  = (state_q != FULL);
    assign in_fire  = InValid && InReady;
    assign out_fire = OutValid && OutReady;

    always_comb begin
        state_d        = state_q;
        main_en        = 1'b0;
        skid_en        = 1'b0;
        main_from_skid = 1'b0;
        case (state_q)
            EMPTY: begin
                if (in_fire) begin
                    main_en = 1'b1;
                    state_d = ONE;
                end
            end
            ONE: begin
                if (in_fire && out_fire) begin
                    main_en = 1'b1;
                end else if (in_fire) begin
                    skid_en = 1'b1;
                    state_d = FULL;
                end else if (out_fire) begin
                    state_d = EMPTY;
                end
            end
            FULL: begin
                if (out_fire) begin
                    main_en        = 1'b1;
                    main_from_skid = 1'b1;
                    state_d        = ONE;
                end
            end
            default: state_d = EMPTY;
        endcase
`ifdef SKID_RX_BUFFER_FLUSH_EN
        // Flush drops both entries but leaves the data registers untouched.
        if (Flush) begin
            state_d = EMPTY;
            main_en = 1'b0;
            skid_en = 1'b0;
        end
`endif
    end

    always_ff @(posedge clk) begin
        if (reset) state_q <= EMPTY;
        else       state_q <= state_d;
    end

    assign main_in = main_from_skid ? skid_q : InData;

    skid_rx_buffer_dff_en #(.WIDTH(WIDTH)) u_main (
        .clk   (clk),
        .reset (reset),
        .en    (main_en),
        .d     (main_in),
        .q     (OutData)
    );

    skid_rx_buffer_dff_en #(.WIDTH(WIDTH)) u_skid (
        .clk   (clk),
        .reset (reset),
        .en    (skid_en),
        .d     (InData),
        .q     (skid_q)
    );
endmodule

// File: tb/tb_skid_rx_buffer.sv
// Directed and randomised checks for skid_rx_buffer; the Flush scenarios compile only with SKID_RX_BUFFER_FLUSH_EN.
module tb_skid_rx_buffer;
    logic       clk = 1'b0;
    logic       reset;
    logic       InValid;
    logic       InReady;
    logic [7:0] InData;
    logic       OutValid;
    logic       OutReady;
    logic [7:0] OutData;
`ifdef SKID_RX_BUFFER_FLUSH_EN
    logic       Flush = 1'b0;
`endif

    int checks   = 0;
    int failures = 0;

    always #5 clk = ~clk;

    skid_rx_buffer #(.WIDTH(8)) dut (
        .clk      (clk),
        .reset    (reset),
`ifdef SKID_RX_BUFFER_FLUSH_EN
        .Flush    (Flush),
`endif
        .InValid  (InValid),
        .InReady  (InReady),
        .InData   (InData),
        .OutValid (OutValid),
        .OutReady (OutReady),
        .OutData  (OutData)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1; InValid = 1'b1; InData = 8'hAA; OutReady = 1'b0;
        tick();
        tick();
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL reset_outvalid got=%b exp=0", OutValid); end
        checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL reset_inready got=%b exp=1", InReady); end
        checks++; if (OutData !== 8'h00) begin failures++; $display("FAIL reset_outdata got=%h exp=00", OutData); end
        reset = 1'b0; InValid = 1'b0; OutReady = 1'b1;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL reset_no_aa cyc=%0d outvalid=%b exp=0", i, OutValid); end
        end
    endtask

    task automatic test_streaming();
        OutReady = 1'b1;
        for (int i = 0; i < 16; i++) begin
            InValid = 1'b1; InData = 8'(i);
            checks++; if (InReady !== 1'b1) begin failures++; $display("FAIL stream_inready i=%0d got=%b exp=1", i, InReady); end
            tick();
            checks++; if (OutValid !== 1'b1 || OutData !== 8'(i)) begin
                failures++; $display("FAIL stream_word i=%0d got v=%b d=%h exp v=1 d=%h", i, OutValid, OutData, 8'(i));
            end
        end
        InValid = 1'b0;
        tick();
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL stream_drained got=%b exp=0", OutValid); end
    endtask

    task automatic test_fill_stall();
        OutReady = 1'b0; InValid = 1'b1; InData = 8'h11;
        tick();
        checks++; if (OutValid !== 1'b1 || OutData !== 8'h11 || InReady !== 1'b1) begin
            failures++; $display("FAIL fill_first got v=%b d=%h r=%b exp v=1 d=11 r=1", OutValid, OutData, InReady);
        end
        InData = 8'h22;
        tick();
        checks++; if (InReady !== 1'b0 || OutData !== 8'h11) begin
            failures++; $display("FAIL fill_full got r=%b d=%h exp r=0 d=11", InReady, OutData);
        end
        InData = 8'h33;
        for (int i = 0; i < 3; i++) begin
            tick();
            checks++; if (InReady !== 1'b0 || OutValid !== 1'b1 || OutData !== 8'h11) begin
                failures++; $display("FAIL fill_stall cyc=%0d got r=%b v=%b d=%h exp r=0 v=1 d=11", i, InReady, OutValid, OutData);
            end
        end
    endtask

    task automatic test_drain();
        OutReady = 1'b1;
        tick();
        checks++; if (OutValid !== 1'b1 || OutData !== 8'h22 || InReady !== 1'b1) begin
            failures++; $display("FAIL drain_second got v=%b d=%h r=%b exp v=1 d=22 r=1", OutValid, OutData, InReady);
        end
        tick();
        checks++; if (OutValid !== 1'b1 || OutData !== 8'h33) begin
            failures++; $display("FAIL drain_third got v=%b d=%h exp v=1 d=33", OutValid, OutData);
        end
        InValid = 1'b0;
        tick();
        checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            failures++; $display("FAIL drain_empty got v=%b r=%b exp v=0 r=1", OutValid, InReady);
        end
    endtask

    task automatic test_reset_mid_full();
        OutReady = 1'b0; InValid = 1'b1; InData = 8'h55;
        tick();
        InData = 8'h66;
        tick();
        checks++; if (InReady !== 1'b0) begin failures++; $display("FAIL rstfull_setup got r=%b exp 0", InReady); end
        reset = 1'b1; OutReady = 1'b1; InData = 8'h77;
        tick();
        checks++; if (OutValid !== 1'b0 || InReady !== 1'b1 || OutData !== 8'h00) begin
            failures++; $display("FAIL rstfull_state got v=%b r=%b d=%h exp v=0 r=1 d=00", OutValid, InReady, OutData);
        end
        reset = 1'b0; InValid = 1'b0;
        tick();
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL rstfull_nodeliver got v=%b exp 0", OutValid); end
    endtask

`ifdef SKID_RX_BUFFER_FLUSH_EN
    task automatic test_flush();
        OutReady = 1'b0; InValid = 1'b1; InData = 8'h11;
        tick();
        InData = 8'h22;
        tick();
        Flush = 1'b1; InData = 8'h44; OutReady = 1'b1;
        tick();
        checks++; if (OutValid !== 1'b0 || InReady !== 1'b1) begin
            failures++; $display("FAIL flush_state got v=%b r=%b exp v=0 r=1", OutValid, InReady);
        end
        Flush = 1'b0; InValid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            tick();
            checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL flush_nodeliver cyc=%0d got v=%b exp 0", i, OutValid); end
        end
        OutReady = 1'b0; InValid = 1'b1; InData = 8'h77;
        tick();
        reset = 1'b1; Flush = 1'b1; InValid = 1'b0;
        tick();
        checks++; if (OutValid !== 1'b0 || OutData !== 8'h00) begin
            failures++; $display("FAIL flush_reset_prio got v=%b d=%h exp v=0 d=00", OutValid, OutData);
        end
        reset = 1'b0; Flush = 1'b0;
        tick();
    endtask
`endif

    task automatic test_random();
        logic [7:0] q[$];
        bit in_f, out_f;
        for (int cyc = 0; cyc < 10000; cyc++) begin
            checks++; if (OutValid !== (q.size() > 0)) begin
                failures++; $display("FAIL rand_outvalid cyc=%0d got=%b exp=%b", cyc, OutValid, q.size() > 0);
            end
            checks++; if (InReady !== (q.size() < 2)) begin
                failures++; $display("FAIL rand_inready cyc=%0d got=%b exp=%b", cyc, InReady, q.size() < 2);
            end
            if (q.size() > 0) begin
                checks++; if (OutData !== q[0]) begin
                    failures++; $display("FAIL rand_outdata cyc=%0d got=%h exp=%h", cyc, OutData, q[0]);
                end
            end
            InValid  = ($urandom_range(0, 9) < 6);
            InData   = 8'($urandom);
            OutReady = ($urandom_range(0, 1) == 1);
            in_f  = InValid && (q.size() < 2);
            out_f = OutReady && (q.size() > 0);
            if (out_f) void'(q.pop_front());
            if (in_f)  q.push_back(InData);
            tick();
        end
        InValid = 1'b0; OutReady = 1'b1;
        tick();
        tick();
        checks++; if (OutValid !== 1'b0) begin failures++; $display("FAIL rand_final_empty got v=%b exp 0", OutValid); end
    endtask

    initial begin
        test_reset();
        test_streaming();
        test_fill_stall();
        test_drain();
        test_reset_mid_full();
`ifdef SKID_RX_BUFFER_FLUSH_EN
        test_flush();
`endif
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
